// File: rtl/zap_rf_pkg.sv
// Shared types and helpers for the zap multi-port register file.
package zap_rf_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Address width for a given entry count, never narrower than one bit.
    function automatic int rf_addr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/zap_rf_clear_fsm.sv
// Clear sequencer: sweeps every entry to zero after reset or on request.
module zap_rf_clear_fsm
    import zap_rf_pkg::*;
#(
    parameter  int DEPTH = 40,
    localparam int AW    = rf_addr_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_clr_req,
    output logic [AW-1:0] o_cnt,
    output logic          o_busy,
    output logic          o_clr_done
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_t    state;
    logic [AW-1:0] cnt;

    // Reset lands in CLEAR so the array is swept before it is ever written.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign o_cnt      = cnt;
    assign o_busy     = (state == CLEAR);
    assign o_clr_done = (state == CLEAR) && (cnt == LAST);

endmodule

// File: rtl/zap_register_file_mp.sv
// Multi-port register file with priority writes, mask broadcast and clear sweep.
// Define ZAP_RF_BYPASS_EN to make same-cycle reads see the winning write.
module zap_register_file_mp
    import zap_rf_pkg::*;
#(
    parameter  int DEPTH = 40,
    parameter  int WIDTH = 32,
    parameter  int NWR   = 2,
    parameter  int NRD   = 4,
    localparam int AW    = rf_addr_width(DEPTH)
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [NWR-1:0]             i_wen,
    input  logic [NWR-1:0][AW-1:0]     i_wr_addr,
    input  logic [NWR-1:0][WIDTH-1:0]  i_wr_data,
    input  logic [DEPTH-1:0]           i_mask_wr,
    input  logic [WIDTH-1:0]           i_mask_data,
    input  logic                       i_clr_req,
    input  logic [NRD-1:0][AW-1:0]     i_rd_addr,
    output logic [NRD-1:0][WIDTH-1:0]  o_rd_data,
    output logic                       o_busy,
    output logic                       o_clr_done
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0]            mem [DEPTH];
    logic [DEPTH-1:0]            ent_we;
    logic [WIDTH-1:0]            ent_wd [DEPTH];
    logic [NRD-1:0][WIDTH-1:0]   rd_next;
    logic [AW-1:0]               clr_cnt;
    logic                        busy;

    zap_rf_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clr_req  (i_clr_req),
        .o_cnt      (clr_cnt),
        .o_busy     (busy),
        .o_clr_done (o_clr_done)
    );

    assign o_busy = busy;

    // Per-entry winner: later assignments override earlier ones, so the mask
    // comes first and the highest-numbered port last. Out-of-range addresses
    // match no entry and simply fall away.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            ent_we[e] = 1'b0;
            ent_wd[e] = '0;
            if (busy) begin
                if (clr_cnt == AW'(e)) begin
                    ent_we[e] = 1'b1;
                end
            end else begin
                if (i_mask_wr[e]) begin
                    ent_we[e] = 1'b1;
                    ent_wd[e] = i_mask_data;
                end
                for (int p = 0; p < NWR; p++) begin
                    if (i_wen[p] && (i_wr_addr[p] == AW'(e))) begin
                        ent_we[e] = 1'b1;
                        ent_wd[e] = i_wr_data[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (ent_we[e]) begin
                mem[e] <= ent_wd[e];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_next[k] = '0;
            if ({1'b0, i_rd_addr[k]} < DEPTH_W) begin
`ifdef ZAP_RF_BYPASS_EN
                rd_next[k] = ent_we[i_rd_addr[k]] ? ent_wd[i_rd_addr[k]]
                                                  : mem[i_rd_addr[k]];
`else
                rd_next[k] = mem[i_rd_addr[k]];
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rd_data <= '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                o_rd_data[k] <= rd_next[k];
            end
        end
    end

endmodule

// File: doc/zap_register_file_mp.md
ZAP_REGISTER_FILE_MP -- requirements
Module: zap_register_file_mp

Interface
REQ-001 SHALL have parameter DEPTH, default 40, number of entries (2..256).
REQ-002 SHALL have parameter WIDTH, default 32, bits per entry.
REQ-003 SHALL have parameter NWR, default 2, indexed write ports.
REQ-004 SHALL have parameter NRD, default 4, read ports; AW = clog2(DEPTH).
REQ-005 SHALL have i_clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have i_reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have i_wen  input  NWR  per-port write enable.
REQ-008 SHALL have i_wr_addr  input  NWR x AW  per-port write address.
REQ-009 SHALL have i_wr_data  input  NWR x WIDTH  per-port write data.
REQ-010 SHALL have i_mask_wr  input  DEPTH  broadcast write, one bit per entry.
REQ-011 SHALL have i_mask_data  input  WIDTH  data for all masked entries.
REQ-012 SHALL have i_clr_req  input  1  single-cycle request to zero the array.
REQ-013 SHALL have i_rd_addr  input  NRD x AW  per-port read address.
REQ-014 SHALL have o_rd_data  output  NRD x WIDTH  registered read data.
REQ-015 SHALL have o_busy  output  1  high while the clear sweep runs.
REQ-016 SHALL have o_clr_done  output  1  one-cycle pulse at sweep end.

Function
REQ-017 Write priority per entry, lowest to highest: mask write, port 0, ..., port NWR-1; highest enabled writer wins.
REQ-018 Write to address >= DEPTH SHALL be dropped without side effects; i_mask_wr bits apply to their entries only.
REQ-019 Read latency SHALL be 1 cycle: o_rd_data[k] in cycle N+1 reflects i_rd_addr[k] sampled in cycle N.
REQ-020 Read of address >= DEPTH SHALL return 0.
REQ-021 Clear FSM states IDLE and CLEAR; IDLE->CLEAR on i_clr_req; CLEAR writes 0 to entry cnt each cycle, cnt 0..DEPTH-1; CLEAR->IDLE after entry DEPTH-1, o_clr_done high that same cycle.
REQ-022 o_busy SHALL equal (state == CLEAR).
REQ-023 During CLEAR, i_wen, i_mask_wr and i_clr_req SHALL be ignored; reads proceed and return current contents.
REQ-024 i_clr_req in the cycle the FSM returns to IDLE SHALL be ignored; it is honoured from the next cycle.
REQ-025 Array storage SHALL have no reset and SHALL be RAM/FF-inferable (no per-entry reset term).

Reset
REQ-026 Assertion of i_reset_n low SHALL immediately force o_rd_data=0, o_clr_done=0, cnt=0, state=CLEAR, o_busy=1.
REQ-027 After deassertion the FSM SHALL sweep all DEPTH entries (DEPTH cycles) before accepting writes; reset mid-sweep restarts at entry 0.

Configuration
REQ-028 Macro ZAP_RF_BYPASS_EN defined: a read whose address matches a winning write in the same cycle SHALL capture that write data (write-through per REQ-017 priority, including mask and clear-sweep writes).
REQ-029 Macro ZAP_RF_BYPASS_EN undefined: same-cycle read SHALL capture the pre-write contents; new value visible from the following read.

Structure
REQ-030 Package zap_rf_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and a clog2-based address-width function.
REQ-031 Clear sequencer SHALL be sub-module zap_rf_clear_fsm (state, cnt, o_busy, o_clr_done); array, write arbitration and read ports stay in the top.

Verification
REQ-032 Reset release, DEPTH=40 -> o_busy=1 for exactly 40 cycles, o_clr_done pulse on 40th, all reads then 0.
REQ-033 Ports 0 and 1 write addr 5 with 0xAAAA0000/0x5555FFFF same cycle, mask bit 5 set with 0x1 -> later read of 5 returns 0x5555FFFF.
REQ-034 Write addr 7 = 0xDEADBEEF while reading addr 7 -> with ZAP_RF_BYPASS_EN next-cycle data 0xDEADBEEF; without, old value, 0xDEADBEEF one read later.
REQ-035 i_mask_wr = bits 0,3,39 with 0x12345678 -> entries 0,3,39 read 0x12345678, entry 1 unchanged.
REQ-036 Write addr 45 = 0xFFFFFFFF, read addr 45 -> no entry changed, read returns 0.
REQ-037 i_clr_req, then i_wen to addr 2 at sweep cycle 10, then reset low at cycle 20 -> write ignored, o_busy stays 1, sweep restarts at entry 0 and completes 40 cycles after release.
